// File: rtl/instruction_loader_if.sv
// Byte-in / word-write bus between the debug UART side and the instruction loader.
// master = loader (consumes bytes, drives the memory write port).
interface instruction_loader_if #(
   parameter int NB_DATA        = 8,
   parameter int NB_INSTRUCTION = 32,
   parameter int NB_ADDR        = 10
);
   logic [NB_DATA-1:0]        i_rx_data;
   logic                      i_rx_valid;
   logic                      o_wr_en;
   logic [NB_ADDR-1:0]        o_wr_addr;
   logic [NB_INSTRUCTION-1:0] o_wr_data;

   modport master (
      input  i_rx_data, i_rx_valid,
      output o_wr_en, o_wr_addr, o_wr_data
   );

   modport slave (
      output i_rx_data, i_rx_valid,
      input  o_wr_en, o_wr_addr, o_wr_data
   );
endinterface

// File: rtl/instruction_loader.sv
// Packs UART bytes (MSB first) into instruction words and writes them from address 0.
// Optional OPCODE_CHECK_EN macro adds a sticky unsupported-opcode flag.
module instruction_loader #(
   parameter int                        NB_DATA        = 8,
   parameter int                        NB_INSTRUCTION = 32,
   parameter int                        NB_ADDR        = 10,
   parameter logic [NB_INSTRUCTION-1:0] HALT_INSTR     = 32'hFFFF_FFFF
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_start,
   instruction_loader_if.master io_bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_overflow,
   output logic [NB_ADDR:0]     o_instr_count,
   output logic                 o_opcode_err
);

   localparam int NB_BYTES = NB_INSTRUCTION / NB_DATA;
   localparam int NB_BCNT  = $clog2(NB_BYTES);
   localparam int NB_SHIFT = NB_INSTRUCTION - NB_DATA;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FULL} state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [NB_SHIFT-1:0]       r_shift;
   logic [NB_BCNT-1:0]        r_bcnt;
   logic [NB_ADDR-1:0]        r_ptr;
   logic [NB_ADDR:0]          r_count;
   logic                      r_wr_en;
   logic [NB_ADDR-1:0]        r_wr_addr;
   logic [NB_INSTRUCTION-1:0] r_wr_data;
   logic [NB_INSTRUCTION-1:0] w_word;
   logic                      w_accept;
   logic                      w_last;
   logic                      w_halt;
   logic                      w_ptr_max;

   always_ff @(posedge i_clock) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_word       = {r_shift, io_bus.i_rx_data};
      w_accept     = i_enable && !i_start && io_bus.i_rx_valid
                     && (r_state == S_LOAD);
      w_last       = w_accept && (r_bcnt == NB_BCNT'(NB_BYTES-1));
      w_halt       = (w_word == HALT_INSTR);
      w_ptr_max    = &r_ptr;
      w_state_next = r_state;
      if (i_enable) begin
         if (i_start)                   w_state_next = S_LOAD;
         else if (w_last && w_halt)     w_state_next = S_DONE;
         else if (w_last && w_ptr_max)  w_state_next = S_FULL;
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_shift   <= '0;
         r_bcnt    <= '0;
         r_ptr     <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (!i_enable) begin
         r_wr_en <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (i_start) begin
            r_shift <= '0;
            r_bcnt  <= '0;
            r_ptr   <= '0;
            r_count <= '0;
         end else if (w_accept) begin
            r_shift <= w_word[NB_SHIFT-1:0];
            r_bcnt  <= r_bcnt + NB_BCNT'(1);
            if (w_last) begin
               r_bcnt    <= '0;
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_ptr;
               r_wr_data <= w_word;
               // pointer parks on the last word; FULL/DONE stop further writes
               if (!w_ptr_max) r_ptr <= r_ptr + NB_ADDR'(1);
               if (!r_count[NB_ADDR]) r_count <= r_count + (NB_ADDR+1)'(1);
            end
         end
      end
   end

`ifdef OPCODE_CHECK_EN
   logic r_opcode_err;

   function automatic logic f_op_ok(input logic [5:0] op);
      f_op_ok = 1'b0;
      case (op) inside
         6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a,
         6'h0c, 6'h0d, 6'h0e, 6'h0f, [6'h20:6'h25],
         6'h28, 6'h29, 6'h2b, 6'h3f: f_op_ok = 1'b1;
         default:                    f_op_ok = 1'b0;
      endcase
   endfunction

   always_ff @(posedge i_clock) begin
      if (!i_reset)
         r_opcode_err <= 1'b0;
      else if (i_enable && i_start)
         r_opcode_err <= 1'b0;
      else if (w_last && !f_op_ok(w_word[NB_INSTRUCTION-1 -: 6]))
         r_opcode_err <= 1'b1;
   end

   assign o_opcode_err = r_opcode_err;
`else
   assign o_opcode_err = 1'b0;
`endif

   assign io_bus.o_wr_en   = r_wr_en & i_enable;
   assign io_bus.o_wr_addr = r_wr_addr;
   assign io_bus.o_wr_data = r_wr_data;
   assign o_busy           = (r_state == S_LOAD);
   assign o_done           = (r_state == S_DONE);
   assign o_overflow       = (r_state == S_FULL);
   assign o_instr_count    = r_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: default depth DUT plus a 4-word DUT
// for the memory-full case, both fed from the same byte stream.
module tb_instruction_loader;

`ifdef OPCODE_CHECK_EN
   localparam bit OPC = 1'b1;
`else
   localparam bit OPC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic start;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instruction_loader_if #(.NB_ADDR(10)) bus_d ();
   instruction_loader_if #(.NB_ADDR(2))  bus_s ();

   assign bus_s.i_rx_data  = bus_d.i_rx_data;
   assign bus_s.i_rx_valid = bus_d.i_rx_valid;

   logic        busy_d, done_d, ovf_d, err_d;
   logic [10:0] cnt_d;
   logic        busy_s, done_s, ovf_s, err_s;
   logic [2:0]  cnt_s;

   instruction_loader #(.NB_ADDR(10)) u_dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_enable      (en),
      .i_start       (start),
      .io_bus        (bus_d),
      .o_busy        (busy_d),
      .o_done        (done_d),
      .o_overflow    (ovf_d),
      .o_instr_count (cnt_d),
      .o_opcode_err  (err_d)
   );

   instruction_loader #(.NB_ADDR(2)) u_small (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_enable      (en),
      .i_start       (start),
      .io_bus        (bus_s),
      .o_busy        (busy_s),
      .o_done        (done_s),
      .o_overflow    (ovf_s),
      .o_instr_count (cnt_s),
      .o_opcode_err  (err_s)
   );

   logic [9:0]  qa_d[$];
   logic [31:0] qd_d[$];
   logic [1:0]  qa_s[$];
   logic [31:0] qd_s[$];

   always @(posedge clk) begin
      if (bus_d.o_wr_en) begin
         qa_d.push_back(bus_d.o_wr_addr);
         qd_d.push_back(bus_d.o_wr_data);
      end
      if (bus_s.o_wr_en) begin
         qa_s.push_back(bus_s.o_wr_addr);
         qd_s.push_back(bus_s.o_wr_data);
      end
   end

   function automatic logic [63:0] ad(int i);
      return (i < qa_d.size()) ? 64'(qa_d[i]) : 64'hBAD;
   endfunction
   function automatic logic [63:0] dd(int i);
      return (i < qd_d.size()) ? 64'(qd_d[i]) : 64'hBAD;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic put(logic [7:0] b, int gap);
      bus_d.i_rx_data  = b;
      bus_d.i_rx_valid = 1'b1;
      cyc();
      bus_d.i_rx_valid = 1'b0;
      cyc(gap);
   endtask

   task automatic clrq();
      qa_d.delete(); qd_d.delete();
      qa_s.delete(); qd_s.delete();
   endtask

   task automatic do_start();
      clrq();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [31:0] bytes;
      int          gap;
      logic [31:0] word;
      bit          done;
      bit          err;
   } vec_t;

   vec_t vt[7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{"addi_like", 32'h2008_0005, 3, 32'h2008_0005, 1'b0, 1'b0};
      vt[1] = '{"halt",      32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vt[2] = '{"bad_op11",  32'h4400_0000, 1, 32'h4400_0000, 1'b0, 1'b1};
      vt[3] = '{"op03",      32'h0C22_00FF, 0, 32'h0C22_00FF, 1'b0, 1'b0};
      vt[4] = '{"op3f_nohalt", 32'hFC00_0001, 2, 32'hFC00_0001, 1'b0, 1'b0};
      vt[5] = '{"op23",      32'h8C00_0000, 0, 32'h8C00_0000, 1'b0, 1'b0};
      vt[6] = '{"bad_op06",  32'h1800_0000, 0, 32'h1800_0000, 1'b0, 1'b1};

      rst_n = 1'b0; en = 1'b1; start = 1'b0;
      bus_d.i_rx_data = 8'h00; bus_d.i_rx_valid = 1'b0;
      cyc();

      // reset held with bytes arriving
      put(8'h55, 0);
      put(8'hAA, 0);
      chk("rst_wr_en",   bus_d.o_wr_en,   0);
      chk("rst_wr_addr", bus_d.o_wr_addr, 0);
      chk("rst_wr_data", bus_d.o_wr_data, 0);
      chk("rst_busy",    busy_d, 0);
      chk("rst_done",    done_d, 0);
      chk("rst_ovf",     ovf_d,  0);
      chk("rst_count",   cnt_d,  0);
      chk("rst_err",     err_d,  0);
      chk("rst_nowr",    qa_d.size(), 0);
      rst_n = 1'b1;
      cyc();

      // bytes in IDLE are ignored
      for (int k = 0; k < 4; k++) put(8'h11, 0);
      cyc(2);
      chk("idle_nowr", qa_d.size(), 0);
      chk("idle_busy", busy_d, 0);

      // table of single-word programs
      for (int i = 0; i < 7; i++) begin
         do_start();
         chk({vt[i].name, "_busy0"}, busy_d, 1);
         for (int k = 0; k < 4; k++)
            put(vt[i].bytes[31-8*k -: 8], vt[i].gap);
         cyc(2);
         chk({vt[i].name, "_nwr"},  qa_d.size(), 1);
         chk({vt[i].name, "_addr"}, ad(0), 0);
         chk({vt[i].name, "_data"}, dd(0), 64'(vt[i].word));
         chk({vt[i].name, "_done"}, done_d, vt[i].done);
         chk({vt[i].name, "_busy"}, busy_d, !vt[i].done);
         chk({vt[i].name, "_cnt"},  cnt_d, 1);
         chk({vt[i].name, "_err"},  err_d, vt[i].err & OPC);
      end

      // slow stream, latency of the write strobe, then HALT
      do_start();
      put(8'h20, 3); put(8'h08, 3); put(8'h00, 3);
      bus_d.i_rx_data = 8'h05; bus_d.i_rx_valid = 1'b1;
      cyc();
      bus_d.i_rx_valid = 1'b0;
      chk("lat_wr_en",   bus_d.o_wr_en,   1);
      chk("lat_wr_addr", bus_d.o_wr_addr, 0);
      chk("lat_wr_data", bus_d.o_wr_data, 32'h2008_0005);
      cyc();
      chk("lat_wr_1cyc", bus_d.o_wr_en,   0);
      cyc(2);
      for (int k = 0; k < 4; k++) put(8'hFF, 3);
      cyc(2);
      chk("t2_nwr",   qa_d.size(), 2);
      chk("t2_a1",    ad(1), 1);
      chk("t2_d1",    dd(1), 32'hFFFF_FFFF);
      chk("t2_done",  done_d, 1);
      chk("t2_busy",  busy_d, 0);
      chk("t2_cnt",   cnt_d,  2);
      for (int k = 0; k < 4; k++) put(8'h12, 0);
      cyc(2);
      chk("t2_after_nwr", qa_d.size(), 2);
      chk("t2_after_cnt", cnt_d, 2);

      // back-to-back bytes across the write cycle
      do_start();
      chk("t3_done_clr", done_d, 0);
      put(8'h00, 0); put(8'h01, 0); put(8'h08, 0); put(8'h20, 0);
      put(8'h3C, 0); put(8'h01, 0); put(8'h00, 0); put(8'h10, 0);
      cyc(2);
      chk("t3_nwr", qa_d.size(), 2);
      chk("t3_a0",  ad(0), 0);
      chk("t3_d0",  dd(0), 32'h0001_0820);
      chk("t3_a1",  ad(1), 1);
      chk("t3_d1",  dd(1), 32'h3C01_0010);
      chk("t3_cnt", cnt_d, 2);
      chk("t3_busy", busy_d, 1);

      // 4-word memory fills without HALT
      do_start();
      for (int w = 1; w <= 4; w++) begin
         put(8'h00, 0); put(8'h00, 0); put(8'h00, 0); put(8'(w), 0);
      end
      cyc(2);
      chk("t4_nwr", qa_s.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_a%0d", i),
             (i < qa_s.size()) ? 64'(qa_s[i]) : 64'hBAD, 64'(i));
         chk($sformatf("t4_d%0d", i),
             (i < qd_s.size()) ? 64'(qd_s[i]) : 64'hBAD, 64'(i + 1));
      end
      chk("t4_ovf",    ovf_s,  1);
      chk("t4_busy",   busy_s, 0);
      chk("t4_cnt",    cnt_s,  4);
      chk("t4_big_ovf", ovf_d, 0);
      for (int k = 0; k < 4; k++) put(8'h07, 0);
      cyc(2);
      chk("t4_after_nwr", qa_s.size(), 4);
      chk("t4_after_cnt", cnt_s, 4);
      do_start();
      chk("t4_ovf_clr", ovf_s, 0);

      // restart mid-word; start beats a same-cycle byte
      put(8'h11, 0); put(8'h22, 0);
      clrq();
      start = 1'b1;
      bus_d.i_rx_data = 8'hAA; bus_d.i_rx_valid = 1'b1;
      cyc();
      start = 1'b0; bus_d.i_rx_valid = 1'b0;
      put(8'h0C, 0); put(8'h22, 0); put(8'h00, 0); put(8'hFF, 0);
      cyc(2);
      chk("t5_nwr", qa_d.size(), 1);
      chk("t5_a0",  ad(0), 0);
      chk("t5_d0",  dd(0), 32'h0C22_00FF);
      chk("t5_cnt", cnt_d, 1);

      // clock enable low drops strobes and freezes state
      do_start();
      put(8'h0C, 0); put(8'h22, 0);
      en = 1'b0;
      bus_d.i_rx_data = 8'h99; bus_d.i_rx_valid = 1'b1;
      cyc();
      bus_d.i_rx_valid = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("en_busy_hold", busy_d, 1);
      en = 1'b1;
      put(8'h00, 0); put(8'hFF, 0);
      cyc(2);
      chk("en_nwr", qa_d.size(), 1);
      chk("en_d0",  dd(0), 32'h0C22_00FF);
      put(8'h00, 0); put(8'h00, 0); put(8'h00, 0); put(8'h09, 0);
      en = 1'b0;
      #1;
      chk("en_wr_forced0", bus_d.o_wr_en, 0);
      chk("en_cnt", cnt_d, 2);
      cyc();
      en = 1'b1;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
